// File: rtl/vector_pkg.sv
// vector_pkg
//   Shared definitions for the vector list sequencer: list word layout,
//   opcode values and the sequencer state encoding.
//   List word (26 bits): {op[1:0], x[11:0], y[11:0]}.
package vector_pkg;

  localparam int WORD_W  = 26;
  localparam int COORD_W = 12;

  // Field positions inside a list word
  localparam int OP_MSB = 25;
  localparam int OP_LSB = 24;
  localparam int X_MSB  = 23;
  localparam int X_LSB  = 12;
  localparam int Y_MSB  = 11;
  localparam int Y_LSB  = 0;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_JUMP = 2'd1,
    OP_DRAW = 2'd2,
    OP_END  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_DECODE    = 3'd3,
    ST_WAIT_RDY  = 3'd4,
    ST_GAP       = 3'd5
  } state_e;

endpackage

// File: rtl/frame_timer.sv
// frame_timer
//   Free-running frame timer. Counts every clock, saturates at all-ones and
//   is cleared when a new frame starts.
// Ports:
//   clk       system clock
//   reset     synchronous active-low reset
//   clear     restart counting from zero (frame start)
//   start_ok  count has reached FRAME_CYCLES-1: a new frame may start
//   expired   count has reached FRAME_CYCLES: the running frame is too long
module frame_timer #(
  parameter int unsigned FRAME_CYCLES = 833333,
  parameter int unsigned FRAME_W      = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic start_ok,
  output logic expired
);

  logic [FRAME_W-1:0] count_q;
  logic [FRAME_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_q != '1) begin
      count_d = count_q + FRAME_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign start_ok = (count_q >= FRAME_W'(FRAME_CYCLES - 1));
  assign expired  = (count_q >= FRAME_W'(FRAME_CYCLES));

endmodule

// File: rtl/vector_list_sequencer.sv
// vector_list_sequencer
//   Walks a double-buffered display list in list RAM and hands one JUMP/DRAW
//   command at a time to the vector control block. The displayed bank is
//   redrawn once per frame period; banks swap at END when requested.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   enable                run frames (0 = stop at next frame boundary)
//   swap_req              pulse: swap displayed bank at next END
//   mem_addr/mem_rd       list RAM read port (data one cycle after mem_rd)
//   mem_data              {op, x, y} list word
//   ctrl_ready            control block idle and able to take a command
//   ctrl_jump/ctrl_draw   one-cycle command pulses
//   ctrl_x/ctrl_y         target, held from one issue until the next
//   bank_disp             bank currently displayed
//   frame_done            one-cycle pulse when END (or a wrap) ends the frame
//   overrun, wrap_err     sticky error flags, cleared only by reset
module vector_list_sequencer
  import vector_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned FRAME_CYCLES = 833333,
  parameter int unsigned FRAME_W      = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               swap_req,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic [WORD_W-1:0]  mem_data,
  input  logic               ctrl_ready,
  output logic               ctrl_jump,
  output logic               ctrl_draw,
  output logic [COORD_W-1:0] ctrl_x,
  output logic [COORD_W-1:0] ctrl_y,
  output logic               bank_disp,
  output logic               frame_done,
  output logic               overrun,
  output logic               wrap_err
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   cmd_q, cmd_d;
  logic [COORD_W-1:0]  x_q, x_d;
  logic [COORD_W-1:0]  y_q, y_d;
  logic                bank_q, bank_d;
  logic                swap_pending_q, swap_pending_d;
  logic                overrun_q, overrun_d;
  logic                wrap_err_q, wrap_err_d;

  logic                timer_clear;
  logic                timer_start_ok;
  logic                timer_expired;
  logic                issue;
  logic                advance;
  logic                end_evt;
  logic                fetch;
  logic                low_last;
  logic [ADDR_W-2:0]   low_inc;
  op_e                 op;

  frame_timer #(
    .FRAME_CYCLES (FRAME_CYCLES),
    .FRAME_W      (FRAME_W)
  ) u_frame_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (timer_clear),
    .start_ok (timer_start_ok),
    .expired  (timer_expired)
  );

  assign op       = op_e'(cmd_q[OP_MSB:OP_LSB]);
  assign low_last = &addr_q[ADDR_W-2:0];
  assign low_inc  = addr_q[ADDR_W-2:0] + (ADDR_W-1)'(1);

  // Next-state logic. Only the low address bits ever move; the bank bit is
  // loaded at frame start and stays put, so walking off the end of a bank
  // wraps to its base and ends the frame as if END had been read.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    cmd_d          = cmd_q;
    x_d            = x_q;
    y_d            = y_q;
    bank_d         = bank_q;
    swap_pending_d = swap_pending_q | swap_req;
    overrun_d      = overrun_q | ((state_q != ST_IDLE) & timer_expired);
    wrap_err_d     = wrap_err_q;
    timer_clear    = 1'b0;
    issue          = 1'b0;
    advance        = 1'b0;
    end_evt        = 1'b0;
    fetch          = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable && timer_start_ok) begin
          addr_d      = {bank_q, {(ADDR_W-1){1'b0}}};
          timer_clear = 1'b1;
          state_d     = ST_FETCH;
        end
      end
      ST_FETCH: begin
        fetch   = 1'b1;
        state_d = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        cmd_d   = mem_data;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        unique case (op)
          OP_NOP:  advance = 1'b1;
          OP_END: begin
            end_evt = 1'b1;
            state_d = ST_IDLE;
          end
          default: state_d = ST_WAIT_RDY;
        endcase
      end
      ST_WAIT_RDY: begin
        // Gating with reset drops a pulse that would coincide with reset.
        if (ctrl_ready && reset) begin
          issue   = 1'b1;
          x_d     = cmd_q[X_MSB:X_LSB];
          y_d     = cmd_q[Y_MSB:Y_LSB];
          state_d = ST_GAP;
        end
      end
      // Control's ready lags its own state update by a cycle, so ready is
      // ignored here; the next fetch overlaps control's work.
      ST_GAP: advance = 1'b1;
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      if (low_last) begin
        wrap_err_d = 1'b1;
        end_evt    = 1'b1;
        addr_d     = {addr_q[ADDR_W-1], {(ADDR_W-1){1'b0}}};
        state_d    = ST_IDLE;
      end else begin
        addr_d  = {addr_q[ADDR_W-1], low_inc};
        state_d = ST_FETCH;
      end
    end

    // A swap_req arriving in the END cycle itself still applies to this frame.
    if (end_evt && (swap_pending_q || swap_req)) begin
      bank_d         = ~bank_q;
      swap_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      cmd_q          <= '0;
      x_q            <= '0;
      y_q            <= '0;
      bank_q         <= 1'b0;
      swap_pending_q <= 1'b0;
      overrun_q      <= 1'b0;
      wrap_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      cmd_q          <= cmd_d;
      x_q            <= x_d;
      y_q            <= y_d;
      bank_q         <= bank_d;
      swap_pending_q <= swap_pending_d;
      overrun_q      <= overrun_d;
      wrap_err_q     <= wrap_err_d;
    end
  end

  // The coordinates go out in the same cycle as the pulse, then hold.
  assign ctrl_x     = issue ? cmd_q[X_MSB:X_LSB] : x_q;
  assign ctrl_y     = issue ? cmd_q[Y_MSB:Y_LSB] : y_q;
  assign ctrl_jump  = issue & (op == OP_JUMP);
  assign ctrl_draw  = issue & (op == OP_DRAW);
  assign mem_rd     = fetch & reset;
  assign frame_done = end_evt & reset;
  assign mem_addr   = addr_q;
  assign bank_disp  = bank_q;
  assign overrun    = overrun_q;
  assign wrap_err   = wrap_err_q;

endmodule

// File: tb/tb_vector_list_sequencer.sv
// tb_vector_list_sequencer
//   Directed bench for vector_list_sequencer with a small list RAM model and
//   a pulse monitor. Runs with 64 words per bank and a 50-cycle frame period.
module tb_vector_list_sequencer;

  localparam int ADDR_W   = 7;
  localparam int FRAME_C  = 50;
  localparam int FRAME_W  = 8;
  localparam int BANK1    = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        swap_req = 1'b0;
  logic        ctrl_ready = 1'b0;
  logic [25:0] mem_data = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic        mem_rd, ctrl_jump, ctrl_draw, bank_disp, frame_done, overrun, wrap_err;
  logic [11:0] ctrl_x, ctrl_y;

  logic [25:0] ram [0:127];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Monitor state
  int iss_n = 0, jump_n = 0, draw_n = 0, done_n = 0, rd_n = 0;
  int gap_err = 0, both_err = 0, last_iss_cyc = 0, done_cyc = 0;
  int iss_type [0:63];
  int iss_x [0:63];
  int iss_y [0:63];
  int iss_cyc [0:63];
  int rd_addr [0:63];
  int rd_cyc [0:63];

  vector_list_sequencer #(
    .ADDR_W       (ADDR_W),
    .FRAME_CYCLES (FRAME_C),
    .FRAME_W      (FRAME_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .swap_req   (swap_req),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .ctrl_ready (ctrl_ready),
    .ctrl_jump  (ctrl_jump),
    .ctrl_draw  (ctrl_draw),
    .ctrl_x     (ctrl_x),
    .ctrl_y     (ctrl_y),
    .bank_disp  (bank_disp),
    .frame_done (frame_done),
    .overrun    (overrun),
    .wrap_err   (wrap_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd) mem_data <= ram[mem_addr];
  end

  // Pulse monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (ctrl_jump || ctrl_draw) begin
      iss_type[iss_n % 64] <= ctrl_jump ? 1 : 2;
      iss_x[iss_n % 64]    <= int'(ctrl_x);
      iss_y[iss_n % 64]    <= int'(ctrl_y);
      iss_cyc[iss_n % 64]  <= cyc;
      if (iss_n > 0 && (cyc - last_iss_cyc) < 2) gap_err <= gap_err + 1;
      last_iss_cyc <= cyc;
      iss_n <= iss_n + 1;
    end
    if (ctrl_jump) jump_n <= jump_n + 1;
    if (ctrl_draw) draw_n <= draw_n + 1;
    if (ctrl_jump && ctrl_draw) both_err <= both_err + 1;
    if (frame_done) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc;
    end
    if (mem_rd) begin
      rd_addr[rd_n % 64] <= int'(mem_addr);
      rd_cyc[rd_n % 64]  <= cyc;
      rd_n <= rd_n + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst_n, input logic en, input logic rdy);
    reset      = rst_n;
    enable     = en;
    ctrl_ready = rdy;
  endtask

  function automatic logic [25:0] mk(input int op, input int x, input int y);
    logic [1:0] o;
    o = op[1:0];
    return {o, x[11:0], y[11:0]};
  endfunction

  task automatic fill_ram(input int op);
    for (int i = 0; i < 128; i++) ram[i] = mk(op, 0, 0);
  endtask

  task automatic do_reset();
    applyStimulus(1'b0, 1'b0, 1'b0);
    swap_req = 1'b0;
    repeat (3) step();
    applyStimulus(1'b1, 1'b0, 1'b0);
  endtask

  task automatic wait_done(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (done_n != base) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic wait_issue(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (iss_n != base) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic wait_rd(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (rd_n != base) begin ok = 1'b1; break; end
      step();
    end
  endtask

  initial begin
    bit ok;
    int ib, db, rb, jb, drb, rc;

    // Reset state
    fill_ram(3);
    do_reset();
    checkOutput("rst_mem_rd", mem_rd, 0);
    checkOutput("rst_jump", ctrl_jump, 0);
    checkOutput("rst_draw", ctrl_draw, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_addr", mem_addr, 0);
    checkOutput("rst_xy", {ctrl_x, ctrl_y}, 0);
    checkOutput("rst_flags", {bank_disp, overrun, wrap_err}, 0);

    // Basic list: JUMP(100,200), DRAW(300,400), END
    $display("[TB] basic list");
    ram[0] = mk(1, 100, 200);
    ram[1] = mk(2, 300, 400);
    ram[2] = mk(3, 0, 0);
    ib = iss_n; db = done_n; jb = jump_n; drb = draw_n;
    applyStimulus(1'b1, 1'b1, 1'b1);
    wait_done(db, 200, ok);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("basic_done_seen", ok, 1);
    checkOutput("basic_jump_cnt", jump_n - jb, 1);
    checkOutput("basic_draw_cnt", draw_n - drb, 1);
    checkOutput("basic_first_type", iss_type[ib % 64], 1);
    checkOutput("basic_first_x", iss_x[ib % 64], 100);
    checkOutput("basic_first_y", iss_y[ib % 64], 200);
    checkOutput("basic_second_type", iss_type[(ib + 1) % 64], 2);
    checkOutput("basic_second_x", iss_x[(ib + 1) % 64], 300);
    checkOutput("basic_second_y", iss_y[(ib + 1) % 64], 400);
    checkOutput("basic_gap_ge2", (iss_cyc[(ib + 1) % 64] - iss_cyc[ib % 64]) >= 2, 1);
    repeat (80) step();
    checkOutput("basic_done_once", done_n - db, 1);
    checkOutput("basic_x_held", ctrl_x, 300);
    checkOutput("basic_y_held", ctrl_y, 400);

    // Ready held low for 500+ cycles at WAIT_RDY
    $display("[TB] ready stall");
    do_reset();
    ram[0] = mk(2, 7, 9);
    ram[1] = mk(3, 0, 0);
    ram[2] = mk(3, 0, 0);
    ib = iss_n; drb = draw_n;
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (560) step();
    checkOutput("stall_no_pulse", draw_n - drb, 0);
    checkOutput("stall_overrun", overrun, 1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    rc = cyc;
    step();
    checkOutput("stall_pulse_cnt", draw_n - drb, 1);
    checkOutput("stall_pulse_cycle", iss_cyc[ib % 64], rc);
    checkOutput("stall_pulse_x", iss_x[ib % 64], 7);
    checkOutput("stall_pulse_y", iss_y[ib % 64], 9);

    // Bank swap
    $display("[TB] bank swap");
    do_reset();
    fill_ram(3);
    ram[0] = mk(1, 1, 2);
    ram[1] = mk(2, 3, 4);
    ram[2] = mk(3, 0, 0);
    ram[BANK1]     = mk(2, 4095, 0);
    ram[BANK1 + 1] = mk(3, 0, 0);
    ib = iss_n; db = done_n;
    applyStimulus(1'b1, 1'b1, 1'b1);
    wait_issue(ib, 200, ok);
    checkOutput("swap_first_issue_seen", ok, 1);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    checkOutput("swap_bank_before_end", bank_disp, 0);
    wait_done(db, 100, ok);
    checkOutput("swap_done_seen", ok, 1);
    checkOutput("swap_bank_after_end", bank_disp, 1);
    rb = rd_n; ib = iss_n; db = done_n;
    wait_rd(rb, 100, ok);
    checkOutput("swap_next_rd_seen", ok, 1);
    checkOutput("swap_next_rd_addr", rd_addr[rb % 64], BANK1);
    wait_issue(ib, 100, ok);
    checkOutput("swap_b1_issue_type", iss_type[ib % 64], 2);
    checkOutput("swap_b1_issue_xy", {iss_x[ib % 64][11:0], iss_y[ib % 64][11:0]}, {12'd4095, 12'd0});
    wait_done(db, 100, ok);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("swap_bank_stays", bank_disp, 1);

    // Overrun: 40 DRAWs with slow ready
    $display("[TB] overrun");
    do_reset();
    fill_ram(3);
    for (int i = 0; i < 40; i++) ram[i] = mk(2, i, i + 1);
    db = done_n; drb = draw_n;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      applyStimulus(1'b1, 1'b1, (k % 3) == 0);
      if (done_n != db) begin ok = 1'b1; break; end
      step();
    end
    checkOutput("ovr_done_seen", ok, 1);
    checkOutput("ovr_draw_cnt", draw_n - drb, 40);
    checkOutput("ovr_flag", overrun, 1);
    checkOutput("ovr_no_wrap", wrap_err, 0);
    rb = rd_n;
    wait_rd(rb, 20, ok);
    checkOutput("ovr_restart_seen", ok, 1);
    checkOutput("ovr_restart_cycle", rd_cyc[rb % 64] - done_cyc, 2);
    checkOutput("ovr_restart_addr", rd_addr[rb % 64], 0);
    applyStimulus(1'b1, 1'b0, 1'b1);

    // Wrap: bank0 all NOPs, no END
    $display("[TB] wrap");
    do_reset();
    fill_ram(0);
    db = done_n; ib = iss_n;
    applyStimulus(1'b1, 1'b1, 1'b1);
    wait_done(db, 500, ok);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("wrap_done_seen", ok, 1);
    checkOutput("wrap_err_flag", wrap_err, 1);
    checkOutput("wrap_addr_base", mem_addr, 0);
    checkOutput("wrap_no_issue", iss_n - ib, 0);
    checkOutput("wrap_bank", bank_disp, 0);

    // Reset while stalled in WAIT_RDY
    $display("[TB] reset mid-frame");
    do_reset();
    fill_ram(3);
    ram[0] = mk(1, 5, 6);
    ram[1] = mk(2, 7, 8);
    ram[2] = mk(3, 0, 0);
    ib = iss_n; drb = draw_n;
    applyStimulus(1'b1, 1'b1, 1'b1);
    wait_issue(ib, 200, ok);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("mid_jump_seen", ok, 1);
    repeat (10) step();
    checkOutput("mid_x_held", ctrl_x, 5);
    applyStimulus(1'b0, 1'b1, 1'b1);
    step();
    checkOutput("mid_outputs_zero",
                {mem_rd, ctrl_jump, ctrl_draw, frame_done, bank_disp, overrun, wrap_err}, 0);
    checkOutput("mid_xy_zero", {ctrl_x, ctrl_y}, 0);
    checkOutput("mid_no_draw", draw_n - drb, 0);
    rb = rd_n; ib = iss_n;
    applyStimulus(1'b1, 1'b1, 1'b1);
    wait_rd(rb, 120, ok);
    checkOutput("mid_restart_seen", ok, 1);
    checkOutput("mid_restart_addr", rd_addr[rb % 64], 0);
    wait_issue(ib, 60, ok);
    checkOutput("mid_restart_jump", iss_type[ib % 64], 1);
    checkOutput("mid_restart_xy", {iss_x[ib % 64][11:0], iss_y[ib % 64][11:0]}, {12'd5, 12'd6});
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (20) step();

    checkOutput("global_gap_violations", gap_err, 0);
    checkOutput("global_double_pulses", both_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
